// File: rtl/dp_hazard_pkg.sv
// Shared definitions for the datapath hazard controller.
// Forward-select codes, register-zero constant and the EX shadow record.
package dp_hazard_pkg;

    localparam int DEF_REG_W = 5;

    typedef logic [DEF_REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        reg_idx_t rs;
        reg_idx_t rt;
        logic     uses_rt;
        reg_idx_t dest;
        logic     regwrite;
        logic     memread;
    } ex_shadow_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Per-operand forward select: the younger MEM producer beats WB,
// and register zero never forwards.
module hazard_fwd_sel
    import dp_hazard_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] src,
    input  logic             use_en,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_regwrite,
    input  logic [REG_W-1:0] wb_dest,
    input  logic             wb_regwrite,
    output logic [1:0]       sel
);

    logic live;

    assign live = use_en && (src != REG_ZERO);

    always_comb begin
        sel = FWD_RF;
        if (live && mem_regwrite && mem_dest == src) begin
            sel = FWD_MEM;
        end else if (live && wb_regwrite && wb_dest == src) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall, branch flush, freeze and forwarding control.
// Define HAZARD_PERF_CNT_EN to add the stall/flush perf counters.
module hazard_ctrl
    import dp_hazard_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    output logic             stall,
    output logic             bubble,
    output logic             flush,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    ex_shadow_t       ex_q;
    logic [REG_W-1:0] mem_dest;
    logic             mem_regwrite;
    logic [REG_W-1:0] wb_dest;
    logic             wb_regwrite;
    logic             lu;

    assign lu = id_valid && ex_q.memread && (ex_q.dest != REG_ZERO) &&
                ((ex_q.dest == id_rs) ||
                 (id_uses_rt && ex_q.dest == id_rt));

    // Gated by rst_n so every control output reads 0 during reset.
    assign freeze = mem_busy && rst_n;
    assign flush  = ex_branch_taken && rst_n && !freeze;
    assign stall  = lu && !freeze && !flush;
    assign bubble = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            mem_dest     <= '0;
            mem_regwrite <= 1'b0;
            wb_dest      <= '0;
            wb_regwrite  <= 1'b0;
        end else if (!freeze) begin
            if (flush || bubble) begin
                ex_q <= '0;
            end else begin
                ex_q.rs       <= id_rs;
                ex_q.rt       <= id_rt;
                ex_q.uses_rt  <= id_uses_rt;
                ex_q.dest     <= id_dest;
                ex_q.regwrite <= id_valid && id_regwrite;
                ex_q.memread  <= id_valid && id_memread;
            end
            mem_dest     <= ex_q.dest;
            mem_regwrite <= ex_q.regwrite;
            wb_dest      <= mem_dest;
            wb_regwrite  <= mem_regwrite;
        end
    end

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_a (
        .src          (ex_q.rs),
        .use_en       (1'b1),
        .mem_dest     (mem_dest),
        .mem_regwrite (mem_regwrite),
        .wb_dest      (wb_dest),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_a)
    );

    hazard_fwd_sel #(.REG_W(REG_W)) u_fwd_b (
        .src          (ex_q.rt),
        .use_en       (ex_q.uses_rt),
        .mem_dest     (mem_dest),
        .mem_regwrite (mem_regwrite),
        .wb_dest      (wb_dest),
        .wb_regwrite  (wb_regwrite),
        .sel          (fwd_b)
    );

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (flush && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
